// File: rtl/vga_pkg.sv
// Shared display constants, motion state encoding and the per-axis bounce helper
// used by the sprite motion controller.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned POS_W    = 10;
  localparam int unsigned ARITH_W  = 11;
  localparam int unsigned SPD_W    = 3;
  localparam int unsigned FRAME_W  = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2
  } motion_state_e;

  typedef struct packed {
    logic             neg;
    logic [POS_W-1:0] pos;
  } axis_t;

  // Speed cycles 1 -> 2 -> 3 -> 4 -> 1.
  function automatic logic [SPD_W-1:0] next_spd(input logic [SPD_W-1:0] s);
    return (s == SPD_W'(4)) ? SPD_W'(1) : s + SPD_W'(1);
  endfunction

  // One move along an axis; a hit on either wall clamps and reverses.
  function automatic axis_t step_axis(input axis_t a, input logic [SPD_W-1:0] spd,
                                      input logic [ARITH_W-1:0] lim);
    logic [ARITH_W-1:0] p;
    logic [ARITH_W-1:0] s;
    axis_t              r;
    p = ARITH_W'(a.pos);
    s = ARITH_W'(spd);
    r = a;
    if (!a.neg) begin
      if (p + s >= lim) begin
        r.pos = POS_W'(lim);
        r.neg = 1'b1;
      end else begin
        r.pos = POS_W'(p + s);
      end
    end else begin
      if (p <= s) begin
        r.pos = '0;
        r.neg = 1'b0;
      end else begin
        r.pos = POS_W'(p - s);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, frame-strobe sampled debounce and a
// single-cycle press event on the strobe where the debounced level rises.
module btn_debounce (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic btn_raw,
  output logic rise_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sample_q, sample_d;
  logic level_q, level_d;

  // Level only follows a value seen identically at two consecutive strobes.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    sample_d = sample_q;
    level_d  = level_q;
    rise_c   = 1'b0;
    if (strobe) begin
      sample_d = sync2_q;
      if (sync2_q == sample_q) begin
        level_d = sync2_q;
        rise_c  = sync2_q & ~level_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sample_q <= sample_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Bouncing-sprite motion controller: moves the sprite once per frame during
// vertical blanking, with pause / speed / single-step buttons.
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned OBJ_W = 151,
  parameter int unsigned OBJ_H = 301,
  parameter int unsigned X0    = 150,
  parameter int unsigned Y0    = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic [2:0]         btn,
  output logic [POS_W-1:0]   obj_x,
  output logic [POS_W-1:0]   obj_y,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               running
);

  localparam int unsigned X_MAX = H_ACTIVE - OBJ_W;
  localparam int unsigned Y_MAX = V_ACTIVE - OBJ_H;

  logic          strobe_c;
  logic [2:0]    ev_c;

  axis_t               x_q, x_d;
  axis_t               y_q, y_d;
  logic [SPD_W-1:0]    spd_q, spd_d;
  motion_state_e       state_q, state_d;
  logic                running_q, running_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;

  assign strobe_c = (hpos == POS_W'(0)) && (vpos == POS_W'(V_ACTIVE));

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce u_db (
      .clk     (clk),
      .reset   (reset),
      .strobe  (strobe_c),
      .btn_raw (btn[i]),
      .rise_c  (ev_c[i])
    );
  end

  // Everything advances on the frame strobe, using state/speed held before it.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    spd_d   = spd_q;
    state_d = state_q;
    frame_d = frame_q;
    if (strobe_c) begin
      frame_d = frame_q + FRAME_W'(1);
      if (state_q != PAUSE) begin
        x_d = step_axis(x_q, spd_q, ARITH_W'(X_MAX));
        y_d = step_axis(y_q, spd_q, ARITH_W'(Y_MAX));
      end
      case (state_q)
        RUN:     if (ev_c[0]) state_d = PAUSE;
        PAUSE: begin
          if (ev_c[0])      state_d = RUN;
          else if (ev_c[2]) state_d = STEP;
        end
        STEP:    state_d = ev_c[0] ? RUN : PAUSE;
        default: state_d = RUN;
      endcase
      if (ev_c[1]) spd_d = next_spd(spd_q);
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '{neg: 1'b0, pos: POS_W'(X0)};
      y_q       <= '{neg: 1'b0, pos: POS_W'(Y0)};
      spd_q     <= SPD_W'(1);
      state_q   <= RUN;
      running_q <= 1'b1;
      frame_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      spd_q     <= spd_d;
      state_q   <= state_d;
      running_q <= running_d;
      frame_q   <= frame_d;
    end
  end

  assign obj_x     = x_q.pos;
  assign obj_y     = y_q.pos;
  assign frame_cnt = frame_q;
  assign running   = running_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed + randomized bench for sprite_motion_ctrl against a frame-level
// behavioural model of the motion rules.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = 10'd5;
  logic [9:0] vpos = 10'd5;
  logic [2:0] btn = 3'd0;
  logic [9:0] obj_x, obj_y;
  logic [7:0] frame_cnt;
  logic       running;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 = run, 1 = pause, 2 = step
  int m_x, m_y, m_spd, m_st, m_frame;
  bit m_xneg, m_yneg;
  bit m_prev[3];
  bit m_lvl[3];

  sprite_motion_ctrl #(.OBJ_W(151), .OBJ_H(301), .X0(150), .Y0(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .hpos      (hpos),
    .vpos      (vpos),
    .btn       (btn),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .frame_cnt (frame_cnt),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      hpos = 10'($urandom_range(0, 799));
      vpos = 10'($urandom_range(0, 479));
      tick();
    end
  endtask

  task automatic model_reset();
    m_x = 150; m_y = 50; m_spd = 1; m_st = 0; m_frame = 0;
    m_xneg = 0; m_yneg = 0;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = 0;
      m_lvl[i]  = 0;
    end
  endtask

  task automatic move(inout int p, inout bit neg, input int s, input int mx);
    if (!neg) begin
      if (p + s >= mx) begin p = mx; neg = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; neg = 0; end
      else p = p - s;
    end
  endtask

  task automatic model_strobe(input logic [2:0] b);
    bit press[3];
    for (int i = 0; i < 3; i++) begin
      press[i] = (b[i] == m_prev[i]) && b[i] && !m_lvl[i];
      if (b[i] == m_prev[i]) m_lvl[i] = b[i];
      m_prev[i] = b[i];
    end
    if (m_st != 1) begin
      move(m_x, m_xneg, m_spd, 640 - 151);
      move(m_y, m_yneg, m_spd, 480 - 301);
    end
    if (press[0])                 m_st = (m_st == 0) ? 1 : 0;
    else if (press[2] && m_st == 1) m_st = 2;
    else if (m_st == 2)           m_st = 1;
    if (press[1]) m_spd = (m_spd == 4) ? 1 : m_spd + 1;
    m_frame = (m_frame + 1) % 256;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_x"}, 32'(obj_x), 32'(m_x));
    check({tag, "_y"}, 32'(obj_y), 32'(m_y));
    check({tag, "_frame"}, 32'(frame_cnt), 32'(m_frame));
    check({tag, "_run"}, 32'(running), 32'(m_st == 0));
  endtask

  // Settle inputs through the synchronizer, confirm outputs held, then strobe.
  task automatic strobe(input string tag);
    idle(3);
    check({tag, "_hold"}, 32'(obj_x), 32'(m_x));
    hpos = 10'd0;
    vpos = 10'd480;
    model_strobe(btn);
    tick();
    hpos = 10'd1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn   = 3'd0;
    hpos  = 10'd0;
    vpos  = 10'd480;
    tick();
    reset = 1'b0;
    hpos  = 10'd7;
    model_reset();
  endtask

  task automatic press(input logic [2:0] b, input string tag);
    btn = b;
    strobe(tag);
    strobe(tag);
    btn = 3'd0;
    strobe(tag);
    strobe(tag);
  endtask

  initial begin
    model_reset();
    do_reset();
    check_all("reset");

    for (int i = 0; i < 3; i++) strobe("free");
    check("r029_x", 32'(obj_x), 32'd153);
    check("r029_y", 32'(obj_y), 32'd53);
    check("r029_frame", 32'(frame_cnt), 32'd3);
    check("r029_run", 32'(running), 32'd1);

    btn = 3'b001;
    strobe("pause1");
    check("pause1_run", 32'(running), 32'd1);
    strobe("pause2");
    check("pause2_run", 32'(running), 32'd0);
    check("pause2_x", 32'(obj_x), 32'd155);
    strobe("pause3");
    check("pause3_x", 32'(obj_x), 32'd155);
    btn = 3'b000;
    strobe("paused");
    strobe("paused");
    check("paused_x", 32'(obj_x), 32'd155);
    check("paused_frame", 32'(frame_cnt), 32'd8);

    btn = 3'b100;
    strobe("step1");
    strobe("step2");
    check("step_enter_x", 32'(obj_x), 32'd155);
    strobe("step3");
    check("step_move_x", 32'(obj_x), 32'd156);
    strobe("step4");
    check("step_held_x", 32'(obj_x), 32'd156);
    btn = 3'b000;
    strobe("step_rel");
    strobe("step_rel");

    idle(2);
    btn = 3'b100;
    tick();
    btn = 3'b000;
    strobe("glitch");
    strobe("glitch");
    check("glitch_x", 32'(obj_x), 32'd156);
    check("glitch_run", 32'(running), 32'd0);

    press(3'b001, "resume");
    for (int k = 0; k < 3; k++) press(3'b010, "speed");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) btn = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        logic [2:0] keep;
        keep = btn;
        idle(1);
        btn = ~keep;
        tick();
        btn = keep;
      end
      strobe("rand");
    end

    do_reset();
    check_all("reset2");
    press(3'b001, "to_pause");
    btn = 3'b100;
    strobe("to_step");
    strobe("to_step");
    btn = 3'b000;
    check("in_step_run", 32'(running), 32'd0);
    do_reset();
    check("rst_step_x", 32'(obj_x), 32'd150);
    check("rst_step_y", 32'(obj_y), 32'd50);
    check("rst_step_frame", 32'(frame_cnt), 32'd0);
    check("rst_step_run", 32'(running), 32'd1);
    strobe("after_rst");
    check("after_rst_x", 32'(obj_x), 32'd151);
    check("after_rst_y", 32'(obj_y), 32'd51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameter OBJ_W, 151, sprite bounding-box width in pixels.
REQ-002 Parameter OBJ_H, 301, sprite bounding-box height in pixels.
REQ-003 Parameter X0, 150, reset x offset (top-left corner).
REQ-004 Parameter Y0, 50, reset y offset (top-left corner).
REQ-005 clk  in  1  single pixel clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 hpos  in  10  current horizontal pixel counter from the sync generator.
REQ-008 vpos  in  10  current vertical line counter from the sync generator.
REQ-009 btn  in  3  raw asynchronous buttons: [0] pause/run, [1] speed, [2] single-step.
REQ-010 obj_x  out  10  sprite x offset for the drawing logic.
REQ-011 obj_y  out  10  sprite y offset for the drawing logic.
REQ-012 frame_cnt  out  8  frame counter.
REQ-013 running  out  1  high when the state is RUN.

Function
REQ-014 Frame strobe SHALL be true in the cycle where hpos==0 and vpos==V_ACTIVE (480); all registers except synchronizers change only on strobe edges, so outputs change only in vertical blanking.
REQ-015 Each btn bit SHALL pass a 2-flop synchronizer; the debounced level updates at a strobe only when the synchronized sample equals the sample taken at the previous strobe.
REQ-016 A press event SHALL fire at the strobe where the debounced level goes 0->1; at most one event per press, however long it is held.
REQ-017 States: RUN, PAUSE, STEP; pause press: RUN->PAUSE, PAUSE->RUN, STEP->RUN; step press: PAUSE->STEP, ignored in RUN/STEP; STEP->PAUSE at the next strobe after performing one move.
REQ-018 Speed press SHALL cycle spd 1->2->3->4->1 pixels/frame; the new speed applies from the next strobe.
REQ-019 At a strobe in RUN or STEP, each axis moves by spd in its direction, using the state and spd held before that strobe; in PAUSE, no movement.
REQ-020 Arithmetic SHALL use 11-bit intermediates; X_MAX = 640-OBJ_W (489), Y_MAX = 480-OBJ_H (179).
REQ-021 Bounce, +direction: if pos+spd >= MAX then pos = MAX and dir flips to -, else pos += spd.
REQ-022 Bounce, -direction: if pos <= spd then pos = 0 and dir flips to +, else pos -= spd; x and y axes are independent, including simultaneous corner hits.
REQ-023 frame_cnt SHALL increment at every strobe regardless of state, wrapping 255->0.
REQ-024 Outputs SHALL be registered; a strobe sampled at edge N makes the new values visible after edge N.

Reset
REQ-025 On reset high at an edge: obj_x=X0, obj_y=Y0, frame_cnt=0, state=RUN (running=1), spd=1, both directions +, synchronizers/debounce/sample registers 0.
REQ-026 Reset SHALL take priority over a coincident strobe and SHALL abort STEP or any in-flight debounce immediately.

Structure
REQ-027 Package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, the state enum (RUN, PAUSE, STEP) and the speed width.
REQ-028 One sub-module, btn_debounce (synchronizer + strobe-sampled debounce + rise-event output), SHALL be instantiated three times.

Verification
REQ-029 Reset, then 3 strobes with no buttons -> obj_x 150->151->152->153, obj_y 50->53, frame_cnt=3, running=1.
REQ-030 btn[0] held high across 3 strobes -> PAUSE entered at the 2nd strobe (running=0); obj_x/obj_y frozen for following strobes while frame_cnt keeps counting.
REQ-031 In PAUSE, step press -> exactly one move at the strobe after STEP is entered, then PAUSE; a held step button produces no second move.
REQ-032 Set spd=4 with obj_x=487 moving + -> next strobe obj_x=489, direction -; following strobe obj_x=485.
REQ-033 Corner case: obj_x=1, obj_y=1, both directions -, spd=2 -> next strobe obj_x=0, obj_y=0, both directions +.
REQ-034 Button glitch lasting 1 cycle between strobes -> no event; reset asserted during STEP -> X0/Y0, RUN, spd=1 on the next edge.
